// File: rtl/ascon_pkg.sv
// ascon_pkg: state encoding, ASCON-128 IV and block-count helpers shared by the phase sequencer
package ascon_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_PA_I, S_KTAIL, S_ADX, S_PB_AD, S_DSEP, S_TX, S_PB_TX, S_FIN, S_PA_F, S_TAG
  } state_t;
  localparam logic [63:0] ASCON_128_IV = 64'h80400c0600000000;
  function automatic int n_ad_blocks(input int a_l, input int r);
    return (a_l == 0) ? 0 : a_l / r + 1;
  endfunction
  function automatic int n_txt_blocks(input int text_l, input int r);
    return text_l / r + 1;
  endfunction
endpackage

// File: rtl/ascon_round_cnt.sv
// ascon_round_cnt: permutation round counter; load_a starts p^a at index 0, load_b starts p^b at A-B
module ascon_round_cnt #(
  parameter int A = 12,
  parameter int B = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load_a,
  input  logic       load_b,
  input  logic       en,
  output logic       last,
  output logic [3:0] round_idx
);
  logic [3:0] rem;
  assign last = rem == '0;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rem <= '0;
      round_idx <= '0;
    end else if (load_a) begin
      rem <= 4'(A - 1);
      round_idx <= '0;
    end else if (load_b) begin
      rem <= 4'(B - 1);
      round_idx <= 4'(A - B);
    end else if (en) begin
      rem <= rem - 4'd1;
      round_idx <= last ? '0 : round_idx + 4'd1;
    end
  end
endmodule

// File: rtl/ascon_phase_ctrl.sv
// ascon_phase_ctrl: ASCON-128 AEAD phase sequencer driving one-hot datapath strobes and round index.
// Optional ASCON_PERF_CNT_EN adds a job-latency counter reported on `cycles`.
module ascon_phase_ctrl
  import ascon_pkg::*;
#(
  parameter int K      = 128,
  parameter int R      = 64,
  parameter int A      = 12,
  parameter int B      = 6,
  parameter int A_L    = 112,
  parameter int TEXT_L = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_start,
  input  logic       dec_start,
  input  logic       abort,
  output logic       busy,
  output logic       enc_done,
  output logic       dec_done,
  output logic       start_err,
  output logic       mode_dec,
  output logic       load_init,
  output logic       key_xor_tail,
  output logic       absorb_ad,
  output logic       dom_sep,
  output logic       absorb_txt,
  output logic       key_xor_pre,
  output logic       tag_cap,
  output logic       round_en,
  output logic [3:0] round_idx,
  output logic [3:0] blk_idx,
  output logic [7:0] cycles
);
  localparam int N_AD = n_ad_blocks(A_L, R);
  localparam int N_T = n_txt_blocks(TEXT_L, R);
  localparam logic [63:0] IV = {8'(K), 8'(R), 8'(A), 8'(B), 32'h0};
  if (IV != ASCON_128_IV) begin : g_iv_check
    $error("ascon_phase_ctrl: parameters do not describe ASCON-128");
  end
  state_t state, nxt;
  logic idle, start, accept, last, load_a, load_b, en, pb_done, txt_last;
  assign idle = state == S_IDLE;
  assign start = enc_start | dec_start;
  assign accept = idle & start;
  assign txt_last = blk_idx == 4'(N_T - 1);
  assign load_a = state == S_INIT || state == S_FIN;
  assign load_b = state == S_ADX || (state == S_TX && !txt_last);
  assign en = state inside {S_PA_I, S_PB_AD, S_PB_TX, S_PA_F};
  assign pb_done = last && (state == S_PB_AD || state == S_PB_TX);
  ascon_round_cnt #(.A(A), .B(B)) u_cnt (
    .clk(clk), .rst(rst), .clr(abort), .load_a(load_a), .load_b(load_b), .en(en),
    .last(last), .round_idx(round_idx)
  );
  always_comb begin
    nxt = state;
    if (idle) nxt = start ? S_INIT : S_IDLE;
    else if (abort) nxt = S_IDLE;
    else
      case (state)
        S_INIT:  nxt = S_PA_I;
        S_PA_I:  nxt = last ? S_KTAIL : S_PA_I;
        S_KTAIL: nxt = (N_AD == 0) ? S_DSEP : S_ADX;
        S_ADX:   nxt = S_PB_AD;
        S_PB_AD: nxt = !last ? S_PB_AD : (blk_idx == 4'(N_AD - 1)) ? S_DSEP : S_ADX;
        S_DSEP:  nxt = S_TX;
        S_TX:    nxt = txt_last ? S_FIN : S_PB_TX;
        S_PB_TX: nxt = last ? S_TX : S_PB_TX;
        S_FIN:   nxt = S_PA_F;
        S_PA_F:  nxt = last ? S_TAG : S_PA_F;
        default: nxt = S_IDLE;
      endcase
  end
  // Strobes are decoded from the next state so every output comes straight from a flop
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy <= 1'b0;
      enc_done <= 1'b0;
      dec_done <= 1'b0;
      start_err <= 1'b0;
      mode_dec <= 1'b0;
      load_init <= 1'b0;
      key_xor_tail <= 1'b0;
      absorb_ad <= 1'b0;
      dom_sep <= 1'b0;
      absorb_txt <= 1'b0;
      key_xor_pre <= 1'b0;
      tag_cap <= 1'b0;
      round_en <= 1'b0;
      blk_idx <= '0;
    end else begin
      state <= nxt;
      busy <= nxt != S_IDLE;
      enc_done <= nxt == S_TAG && !mode_dec;
      dec_done <= nxt == S_TAG && mode_dec;
      start_err <= start && (!idle || (enc_start && dec_start));
      mode_dec <= accept ? !enc_start : mode_dec;
      load_init <= nxt == S_INIT;
      key_xor_tail <= nxt == S_KTAIL;
      absorb_ad <= nxt == S_ADX;
      dom_sep <= nxt == S_DSEP;
      absorb_txt <= nxt == S_TX;
      key_xor_pre <= nxt == S_FIN;
      tag_cap <= nxt == S_TAG;
      round_en <= nxt inside {S_PA_I, S_PB_AD, S_PB_TX, S_PA_F};
      blk_idx <= (nxt == S_IDLE || state == S_KTAIL || state == S_DSEP) ? '0 :
                 (pb_done && blk_idx != 4'hf) ? blk_idx + 4'd1 : blk_idx;
    end
  end
`ifdef ASCON_PERF_CNT_EN
  logic [7:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      cycles <= '0;
    end else begin
      cnt <= accept ? '0 : busy ? cnt + 8'd1 : cnt;
      cycles <= tag_cap ? cnt : cycles;
    end
  end
`else
  assign cycles = '0;
`endif
endmodule

// File: tb/tb_ascon_phase_ctrl.sv
// tb_ascon_phase_ctrl: per-cycle strobe schedule scoreboard for default and A_L=0 sequencers
module tb_ascon_phase_ctrl;
  localparam int A = 12;
  localparam int B = 6;
  localparam logic [7:0] S_LI = 8'h80, S_KT = 8'h40, S_AD = 8'h20, S_DS = 8'h10;
  localparam logic [7:0] S_TX = 8'h08, S_KP = 8'h04, S_TG = 8'h02, S_RE = 8'h01;
  localparam logic [20:0] M_ALL = 21'h1FFFFF, M_NOBLK = 21'h1FFFF0, M_IDLE = 21'h1EFFF0;
  typedef struct packed {
    logic [7:0] s;
    logic [3:0] r;
    logic [3:0] b;
    logic       c;
  } cyc_t;
  typedef struct {
    logic  enc;
    logic  dec;
    logic  abt;
    int    al0;
    int    poke;
    string name;
  } job_t;
  logic clk = 0, rst = 1, enc_start = 0, dec_start = 0, abort = 0;
  logic [1:0] busy, enc_done, dec_done, start_err, mode_dec, load_init, key_xor_tail;
  logic [1:0] absorb_ad, dom_sep, absorb_txt, key_xor_pre, tag_cap, round_en;
  logic [3:0] round_idx [2];
  logic [3:0] blk_idx [2];
  logic [7:0] cycles [2];
  cyc_t q[$];
  job_t jobs[6];
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  ascon_phase_ctrl dut (
    .clk(clk), .rst(rst), .enc_start(enc_start), .dec_start(dec_start), .abort(abort),
    .busy(busy[0]), .enc_done(enc_done[0]), .dec_done(dec_done[0]), .start_err(start_err[0]),
    .mode_dec(mode_dec[0]), .load_init(load_init[0]), .key_xor_tail(key_xor_tail[0]),
    .absorb_ad(absorb_ad[0]), .dom_sep(dom_sep[0]), .absorb_txt(absorb_txt[0]),
    .key_xor_pre(key_xor_pre[0]), .tag_cap(tag_cap[0]), .round_en(round_en[0]),
    .round_idx(round_idx[0]), .blk_idx(blk_idx[0]), .cycles(cycles[0])
  );
  ascon_phase_ctrl #(.A_L(0)) dut0 (
    .clk(clk), .rst(rst), .enc_start(enc_start), .dec_start(dec_start), .abort(abort),
    .busy(busy[1]), .enc_done(enc_done[1]), .dec_done(dec_done[1]), .start_err(start_err[1]),
    .mode_dec(mode_dec[1]), .load_init(load_init[1]), .key_xor_tail(key_xor_tail[1]),
    .absorb_ad(absorb_ad[1]), .dom_sep(dom_sep[1]), .absorb_txt(absorb_txt[1]),
    .key_xor_pre(key_xor_pre[1]), .tag_cap(tag_cap[1]), .round_en(round_en[1]),
    .round_idx(round_idx[1]), .blk_idx(blk_idx[1]), .cycles(cycles[1])
  );
  function automatic logic [20:0] obs(input int k);
    return {busy[k], enc_done[k], dec_done[k], start_err[k], mode_dec[k], load_init[k],
            key_xor_tail[k], absorb_ad[k], dom_sep[k], absorb_txt[k], key_xor_pre[k],
            tag_cap[k], round_en[k], round_idx[k], blk_idx[k]};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp,
                       input logic [20:0] mask);
    vecs++;
    if ((act & mask) !== (exp & mask)) begin
      errs++;
      $display("FAIL %s: got %h expected %h (mask %h)", name, act, exp, mask);
    end
  endtask
  task automatic push(input logic [7:0] s, input int r, input int b, input logic c);
    q.push_back('{s, 4'(r), 4'(b), c});
  endtask
  // Expected per-cycle schedule derived from the phase sequence, rounds and block counts
  task automatic sched(input int nad);
    push(S_LI, 0, 0, 0);
    for (int r = 0; r < A; r++) push(S_RE, r, 0, 0);
    push(S_KT, 0, 0, 0);
    for (int b = 0; b < nad; b++) begin
      push(S_AD, 0, b, 1);
      for (int r = A - B; r < A; r++) push(S_RE, r, b, 1);
    end
    push(S_DS, 0, 0, 0);
    for (int b = 0; b < 3; b++) begin
      push(S_TX, 0, b, 1);
      if (b < 2) for (int r = A - B; r < A; r++) push(S_RE, r, b, 1);
    end
    push(S_KP, 0, 0, 0);
    for (int r = 0; r < A; r++) push(S_RE, r, 0, 0);
    push(S_TG, 0, 0, 0);
  endtask
  function automatic logic [20:0] expect_of(input cyc_t c, input logic dec, input logic err);
    return {1'b1, c.s == S_TG && !dec, c.s == S_TG && dec, err, dec, c.s, c.r, c.b};
  endfunction
  task automatic wait_idle();
    int i = 0;
    while (busy != 2'b00 && i < 100) begin
      step();
      i++;
    end
    if (busy != 2'b00) begin
      vecs++;
      errs++;
      $display("FAIL wait_idle: busy=%b required 00", busy);
    end
  endtask
  task automatic run_job(input job_t j);
    int k = j.al0;
    int cyc = 0;
    logic dec = !j.enc && j.dec;
    int exp_cyc;
    cyc_t c;
    sched(k ? 0 : 2);
    exp_cyc = k ? 43 : 57;
    enc_start = j.enc;
    dec_start = j.dec;
    abort = j.abt;
    step();
    enc_start = 0;
    dec_start = 0;
    abort = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      check($sformatf("%s@E%0d", j.name, cyc), obs(k),
            expect_of(c, dec, (cyc == 0 && j.enc && j.dec) || (j.poke != 0 && cyc == j.poke)),
            c.c ? M_ALL : M_NOBLK);
      dec_start = (cyc == j.poke - 1);
      step();
      cyc++;
    end
    dec_start = 0;
    check($sformatf("%s_idle", j.name), obs(k), '0, M_IDLE);
`ifdef ASCON_PERF_CNT_EN
    check($sformatf("%s_cycles", j.name), 21'(cycles[k]), 21'(exp_cyc), M_ALL);
`else
    check($sformatf("%s_cycles", j.name), 21'(cycles[k]), 21'(0), M_ALL);
    if (exp_cyc < 0) $display("exp_cyc %0d", exp_cyc);
`endif
    wait_idle();
  endtask
  initial begin
    cyc_t c;
    jobs[0] = '{1'b1, 1'b0, 1'b0, 0, 0, "enc"};
    jobs[1] = '{1'b0, 1'b1, 1'b0, 0, 0, "dec"};
    jobs[2] = '{1'b1, 1'b0, 1'b0, 1, 0, "enc_al0"};
    jobs[3] = '{1'b1, 1'b1, 1'b0, 0, 10, "both_poke"};
    jobs[4] = '{1'b1, 1'b0, 1'b1, 0, 0, "start_abort"};
    jobs[5] = '{1'b0, 1'b1, 1'b0, 1, 0, "dec_al0"};
    repeat (3) step();
    check("reset0", obs(0), '0, M_ALL);
    check("reset1", obs(1), '0, M_ALL);
    check("reset_cycles", 21'({cycles[0], cycles[1]}), '0, M_ALL);
    rst = 0;
    abort = 1;
    step();
    abort = 0;
    check("idle_abort", obs(0), '0, M_ALL);
    for (int i = 0; i < 6; i++) run_job(jobs[i]);
    // Abort sampled at E21, then a fresh start at E25 must run to completion
    sched(2);
    enc_start = 1;
    step();
    enc_start = 0;
    for (int cyc = 0; cyc <= 20; cyc++) begin
      c = q.pop_front();
      check($sformatf("pre_abort@E%0d", cyc), obs(0), expect_of(c, 1'b0, 1'b0), c.c ? M_ALL : M_NOBLK);
      abort = (cyc == 20);
      step();
    end
    abort = 0;
    q.delete();
    for (int cyc = 21; cyc <= 24; cyc++) begin
      check($sformatf("aborted@E%0d", cyc), obs(0), '0, M_IDLE);
      check($sformatf("aborted0@E%0d", cyc), obs(1), '0, M_IDLE);
      if (cyc < 24) step();
    end
    run_job('{1'b1, 1'b0, 1'b0, 0, 0, "restart"});
    // Synchronous reset sampled at E31 during a decrypt job
    sched(2);
    dec_start = 1;
    step();
    dec_start = 0;
    for (int cyc = 0; cyc <= 30; cyc++) begin
      c = q.pop_front();
      check($sformatf("pre_rst@E%0d", cyc), obs(0), expect_of(c, 1'b1, 1'b0), c.c ? M_ALL : M_NOBLK);
      rst = (cyc == 30);
      step();
    end
    q.delete();
    check("mid_rst0", obs(0), '0, M_ALL);
    check("mid_rst1", obs(1), '0, M_ALL);
    check("mid_rst_cycles", 21'({cycles[0], cycles[1]}), '0, M_ALL);
    rst = 0;
    step();
    check("post_rst", obs(0), '0, M_ALL);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
